mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 143 ++++++++++++++
 tb/tb_mult_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external combinational multiplier among N_REQ requesters.
// One transaction in flight: IDLE grants, MUL waits MUL_LAT cycles, RESP holds the product.
module mult_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 4,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [2*W-1:0]           rsp_data,
  output logic [W-1:0]             mul_a,
  output logic [W-1:0]             mul_b,
  input  logic [2*W-1:0]           mul_p,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [7:0]               done_cnt
);
  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MUL_LAT + 1);
  localparam logic [IdW-1:0]  LastId  = IdW'(N_REQ - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MUL_LAT - 1);

  typedef enum logic [1:0] {StIdle, StMul, StResp} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [2*W-1:0]  data_q, data_d;
  logic [7:0]      done_q, done_d;

  logic            found;
  logic [IdW-1:0]  pick;
  logic [IdW:0]    cand;
  logic [W-1:0]    pick_a, pick_b;

  // First valid requester at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdW+1)'(k);
      if (cand >= (IdW+1)'(N_REQ)) cand = cand - (IdW+1)'(N_REQ);
      if (!found && req_valid[cand[IdW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IdW-1:0];
      end
    end
  end

  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick == IdW'(i)) begin
        pick_a = req_a[i*W +: W];
        pick_b = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    done_d    = done_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          // Grant and handshake coincide: the winner is by construction valid.
          req_ready[pick] = ~rst;
          a_d     = pick_a;
          b_d     = pick_b;
          grant_d = pick;
          cnt_d   = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        if (cnt_q == LastCnt) begin
          data_d  = mul_p;
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          rr_ptr_d = (grant_q == LastId) ? '0 : grant_q + 1'b1;
          done_d   = done_q + 8'd1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign mul_a    = a_q;
  assign mul_b    = b_q;
  assign rsp_data = data_q;
  assign grant_id = grant_q;
  assign done_cnt = done_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomised scoreboard bench for mult_arbiter, plus a MUL_LAT=3 instance for latency and
// mid-transaction reset.
module tb_mult_arbiter;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [2*W-1:0] rsp_data, mul_p;
  logic [W-1:0]   mul_a, mul_b;
  logic           busy;
  logic [1:0]     grant_id;
  logic [7:0]     done_cnt;

  logic [N-1:0]   req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [N*W-1:0] req_a3, req_b3;
  logic [2*W-1:0] rsp_data3, mul_p3;
  logic [W-1:0]   mul_a3, mul_b3;
  logic           busy3;
  logic [1:0]     grant_id3;
  logic [7:0]     done_cnt3;

  assign mul_p  = (2*W)'(mul_a) * (2*W)'(mul_b);
  assign mul_p3 = (2*W)'(mul_a3) * (2*W)'(mul_b3);

  mult_arbiter #(.N_REQ(N), .W(W), .MUL_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
    .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy), .grant_id(grant_id),
    .done_cnt(done_cnt)
  );

  mult_arbiter #(.N_REQ(N), .W(W), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_a(req_a3),
    .req_b(req_b3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3), .busy(busy3), .grant_id(grant_id3),
    .done_cnt(done_cnt3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of the arbiter.
  typedef struct {
    int             id;
    logic [2*W-1:0] prod;
  } exp_t;
  exp_t sbq[$];
  int   m_ptr, m_id, m_wait, m_total, cyc, last_grant;
  bit   m_idle, wrap_pending;
  logic [7:0] m_done;
  int   glog[$];
  int   gcyc[$];

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] pk(input int i, input logic [W-1:0] x);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = x;
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_idle = 1; m_wait = 0; m_id = 0; m_done = 0; m_total = 0;
    wrap_pending = 0; last_grant = -1;
    sbq.delete();
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                      input logic [N-1:0] rr);
    logic [N-1:0] e_rdy, e_rspv;
    logic [W-1:0] oa, ob;
    int           w;
    exp_t         e;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    #1;
    cyc++;
    e_rdy = '0; e_rspv = '0; last_grant = -1;
    check("done_cnt", done_cnt, m_done);
    if (wrap_pending) begin
      check("done_wrap256", done_cnt, 0);
      wrap_pending = 0;
    end
    check("busy", busy, !m_idle);
    if (!m_idle) check("grant_id", grant_id, m_id);
    if (m_idle) begin
      w = rr_pick(v, m_ptr);
      if (w >= 0) begin
        e_rdy[w] = 1'b1;
        oa = W'(a >> (w*W));
        ob = W'(b >> (w*W));
        e.id = w;
        e.prod = (2*W)'(oa) * (2*W)'(ob);
        sbq.push_back(e);
        m_idle = 0; m_id = w; m_wait = LAT; last_grant = w;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      e_rspv[m_id] = 1'b1;
      if (rr[m_id]) begin
        m_idle = 1; m_ptr = (m_id + 1) % N; m_done++; m_total++;
        if (m_total == 256) wrap_pending = 1;
      end
    end
    check("req_ready", req_ready, e_rdy);
    check("rsp_valid", rsp_valid, e_rspv);
    for (int i = 0; i < N; i++) if (req_ready[i]) begin glog.push_back(i); gcyc.push_back(cyc); end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '1);
  endtask

  task automatic txn(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] expd, input string nm);
    step(N'(1) << i, pk(i, a), pk(i, b), '1);
    idle_steps(2);
    check(nm, rsp_data, expd);
    idle_steps(1);
  endtask

  task automatic main_reset_checks(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_done_cnt"}, done_cnt, 0);
    check({tag, "_mul_ab"}, {mul_a, mul_b}, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req_valid = '1;
    #1;
    main_reset_checks("rst");
    model_reset();
    @(negedge clk);
    rst = 0; req_valid = '0;
  endtask

  // Monitor: compares every presented response against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_unexpected: rsp_valid=%b, expected no response", rsp_valid);
        end else begin
          check("rsp_id", rsp_valid, 32'(1) << sbq[0].id);
          check("rsp_data", rsp_data, sbq[0].prod);
          if ((rsp_valid & rsp_ready) != '0) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [N-1:0]   cv, crr;
    logic [N*W-1:0] ca, cb, hold_a;
    int             order29[5];
    int             order30[3];
    order29 = '{0, 1, 2, 3, 0};
    order30 = '{2, 3, 0};
    cyc = 0;
    model_reset();
    rst = 1;
    req_valid = '1; req_a = '1; req_b = '1; rsp_ready = '0;
    req_valid3 = '1; req_a3 = '1; req_b3 = '1; rsp_ready3 = '0;
    repeat (2) @(negedge clk);
    #1;
    main_reset_checks("rst0");
    check("rst0_d3_req_ready", req_ready3, 0);
    check("rst0_d3_busy", busy3, 0);
    @(negedge clk);
    rst = 0; req_valid = '0; req_valid3 = '0; rsp_ready = '1; rsp_ready3 = '1;

    // MUL_LAT=3 instance: latency, then reset in the middle of MUL.
    @(negedge clk);
    req_valid3 = 4'b0100; req_a3 = 16'h0700; req_b3 = 16'h0900;
    #1;
    check("d3_grant", req_ready3, 4'b0100);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req_valid3 = '0;
      #1;
      check("d3_mul_busy", busy3, 1);
      check("d3_mul_rspv", rsp_valid3, 0);
      check("d3_mul_ops", {mul_a3, mul_b3}, 8'h79);
    end
    @(negedge clk);
    #1;
    check("d3_rspv", rsp_valid3, 4'b0100);
    check("d3_data", rsp_data3, 63);
    @(negedge clk);
    #1;
    check("d3_idle", busy3, 0);
    check("d3_done", done_cnt3, 1);
    req_valid3 = 4'b0001; req_a3 = 16'h000f; req_b3 = 16'h000f;
    #1;
    check("d3_grant0", req_ready3, 4'b0001);
    @(negedge clk);
    req_valid3 = '0;
    #1;
    check("d3_in_mul", busy3, 1);
    @(negedge clk);
    rst = 1;
    #1;
    check("d3_rst_busy", busy3, 0);
    check("d3_rst_rspv", rsp_valid3, 0);
    check("d3_rst_done", done_cnt3, 0);
    check("d3_rst_data", rsp_data3, 0);
    check("d3_rst_ops", {mul_a3, mul_b3}, 0);
    check("d3_rst_gid", grant_id3, 0);
    model_reset();
    @(negedge clk);
    rst = 0; req_valid3 = 4'b1001;
    #1;
    check("d3_first_grant", req_ready3, 4'b0001);
    @(negedge clk);
    req_valid3 = '0;

    // Directed cases on the MUL_LAT=1 instance.
    txn(1, 4'd3, 4'd5, 8'd15, "r27_data");
    check("r27_done", done_cnt, 1);
    txn(0, 4'd15, 4'd15, 8'd225, "r28_max");
    txn(3, 4'd0, 4'd15, 8'd0, "r28_zero");

    do_reset();
    glog.delete(); gcyc.delete();
    hold_a = N*W'($urandom);
    for (int i = 0; i < 15; i++) step('1, hold_a, ~hold_a, '1);
    while (glog.size() < 5) begin glog.push_back(-1); gcyc.push_back(-100); end
    for (int i = 0; i < 5; i++) check("r29_order", glog[i], order29[i]);
    for (int i = 1; i < 5; i++) check("r29_interval", gcyc[i] - gcyc[i-1], LAT + 2);
    idle_steps(4);

    glog.delete(); gcyc.delete();
    txn(2, 4'd6, 4'd7, 8'd42, "r30_data");
    for (int i = 0; i < 6; i++) step(4'b1001, pk(3, 4'd2) | pk(0, 4'd9), '1, '1);
    while (glog.size() < 3) glog.push_back(-1);
    for (int i = 0; i < 3; i++) check("r30_order", glog[i], order30[i]);

    step(4'b0001, pk(0, 4'd13), pk(0, 4'd11), 4'b1110);
    step(4'b1110, '0, '0, 4'b1110);
    for (int i = 0; i < 5; i++) begin
      step(4'b1110, '0, '0, 4'b1110);
      check("r31_hold_data", rsp_data, 143);
      check("r31_hold_rspv", rsp_valid, 4'b0001);
    end
    step(4'b1110, '0, '0, 4'b0001);
    step(4'b1110, '0, '0, '1);
    check("r31_next_grant", req_ready, 4'b0010);
    idle_steps(4);

    // Random traffic: requests held until granted, occasional drops, random backpressure.
    cv = '0; ca = '0; cb = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (cv[i]) begin
          if (last_grant == i || $urandom_range(0, 15) == 0) cv[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          cv[i] = 1'b1;
          ca[i*W +: W] = rnd_op();
          cb[i*W +: W] = rnd_op();
        end
      end
      crr = N'($urandom) | N'($urandom);
      step(cv, ca, cb, crr);
    end
    idle_steps(8);
    check("sb_empty", sbq.size(), 0);
    check("wrapped_once", m_total > 256, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
